alu_result_fifo: RTL and testbench

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_fifo_mem.sv | 25 ++
 rtl/alu_result_fifo.sv | 89 ++++++++
 tb/tb_alu_result_fifo.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bit positions, data width and the stored
// result entry (flags in the top nibble, Z below).
package alu_pkg;

  localparam int DATA_W     = 32;
  localparam int FLAG_W     = 4;
  localparam int ENTRY_W    = DATA_W + FLAG_W;

  localparam int FLAG_OVF   = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_ZERO  = 2;

  typedef struct packed {
    logic [FLAG_W-1:0] flags;
    logic [DATA_W-1:0] z;
  } alu_entry_t;

endpackage

// File: rtl/alu_fifo_mem.sv
// DEPTH x 36-bit result storage: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module alu_fifo_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  alu_entry_t    wdata,
  input  logic [AW-1:0] raddr,
  output alu_entry_t    rdata
);

  alu_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// Result FIFO behind the ALU: queues {flags, z} pairs, keeps sticky
// overflow/carry bits and a saturating count of accepted results.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_z,
  input  logic [FLAG_W-1:0] in_flags,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_z,
  output logic [FLAG_W-1:0] out_flags,
  input  logic              clr_sticky,
  output logic              sticky_ovf,
  output logic              sticky_carry,
  output logic [CNT_W-1:0]  result_count
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  alu_entry_t    wr_entry;
  alu_entry_t    rd_entry;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; ready never looks at valid, so when full a same-cycle pop does
  // not open a slot for the incoming result.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign wr_entry  = '{flags: in_flags, z: in_z};

  alu_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign out_z     = rd_entry.z;
  assign out_flags = rd_entry.flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A setting push in the same cycle as clr_sticky keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf   <= 1'b0;
      sticky_carry <= 1'b0;
      result_count <= '0;
    end else begin
      if (push && in_flags[FLAG_OVF])        sticky_ovf <= 1'b1;
      else if (clr_sticky)                   sticky_ovf <= 1'b0;
      if (push && in_flags[FLAG_CARRY])      sticky_carry <= 1'b1;
      else if (clr_sticky)                   sticky_carry <= 1'b0;
      if (push && (result_count != '1))      result_count <= result_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: directed scenarios plus a random
// run against a queue-based reference model (two instances, CNT_W=16 and 4).
module tb_alu_result_fifo;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_z;
  logic [3:0]  in_flags;
  logic        out_ready;
  logic        clr_sticky;

  logic        in_ready,  in_ready_c4;
  logic        out_valid, out_valid_c4;
  logic [31:0] out_z,     out_z_c4;
  logic [3:0]  out_flags, out_flags_c4;
  logic        sticky_ovf,   sticky_ovf_c4;
  logic        sticky_carry, sticky_carry_c4;
  logic [15:0] result_count;
  logic [3:0]  result_count_c4;

  // reference model
  logic [35:0] exp_q[$];
  logic        m_sovf;
  logic        m_scarry;
  int          m_cnt16;
  int          m_cnt4;

  int n_cmp = 0;
  int n_err = 0;

  alu_result_fifo #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_z(in_z), .in_flags(in_flags),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_flags(out_flags), .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf),
    .sticky_carry(sticky_carry), .result_count(result_count)
  );

  alu_result_fifo #(.DEPTH(DEPTH), .CNT_W(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_z(in_z), .in_flags(in_flags),
    .in_ready(in_ready_c4), .out_valid(out_valid_c4), .out_ready(out_ready), .out_z(out_z_c4),
    .out_flags(out_flags_c4), .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf_c4),
    .sticky_carry(sticky_carry_c4), .result_count(result_count_c4)
  );

  // clock / timeout
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete (got running, want finished)");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_z       = '0;
    in_flags   = '0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_sovf   = 1'b0;
    m_scarry = 1'b0;
    m_cnt16  = 0;
    m_cnt4   = 0;
  endtask

  // Applies the current inputs to the model, then advances to the next negedge.
  task automatic cycle();
    bit push, pop;
    push = in_valid && (exp_q.size() != DEPTH);
    pop  = (exp_q.size() != 0) && out_ready;
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      exp_q.push_back({in_flags, in_z});
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15)     m_cnt4++;
    end
    m_sovf   = (push && in_flags[0]) ? 1'b1 : (clr_sticky ? 1'b0 : m_sovf);
    m_scarry = (push && in_flags[1]) ? 1'b1 : (clr_sticky ? 1'b0 : m_scarry);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // scenarios
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_clear();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if ({sticky_ovf, sticky_carry} !== 2'b00) begin n_err++; $display("FAIL reset_sticky got %b%b want 00", sticky_ovf, sticky_carry); end
    n_cmp++; if (result_count !== 16'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", result_count); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_push();
    in_valid = 1'b1; in_z = 32'h5; in_flags = 4'b0100; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", out_valid); end
    n_cmp++; if (out_z !== 32'h5) begin n_err++; $display("FAIL single_z got %h want 00000005", out_z); end
    n_cmp++; if (out_flags !== 4'b0100) begin n_err++; $display("FAIL single_flags got %b want 0100", out_flags); end
    n_cmp++; if (result_count !== 16'd1) begin n_err++; $display("FAIL single_count got %0d want 1", result_count); end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", out_valid); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_z = 32'(i); in_flags = 4'(i); out_ready = 1'b0;
      cycle();
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    in_z = 32'h5;
    cycle();
    in_valid = 1'b0;
    n_cmp++; if (result_count !== 16'd4) begin n_err++; $display("FAIL full_ignored_count got %0d want 4", result_count); end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_z !== 32'(i)) begin
        n_err++; $display("FAIL drain_%0d got valid=%b z=%h want valid=1 z=%h", i, out_valid, out_z, 32'(i));
      end
      cycle();
    end
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got %b want 0", out_valid); end
  endtask

  task automatic test_full_push_pop();
    int pops;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_z = $urandom; in_flags = 4'b0000;
      cycle();
    end
    in_z = 32'hDEAD_BEEF; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fullpp_in_ready got %b want 1", in_ready); end
    n_cmp++; if (result_count !== 16'd4) begin n_err++; $display("FAIL fullpp_count got %0d want 4", result_count); end
    pops = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 8 && out_valid === 1'b1; k++) begin
      pops++;
      cycle();
    end
    out_ready = 1'b0;
    n_cmp++; if (pops !== 3) begin n_err++; $display("FAIL fullpp_occupancy got %0d want 3", pops); end
  endtask

  task automatic test_sticky();
    do_reset();
    in_valid = 1'b1; in_z = 32'h7; in_flags = 4'b0001; clr_sticky = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    n_cmp++; if (sticky_ovf !== 1'b1) begin n_err++; $display("FAIL sticky_set_wins got %b want 1", sticky_ovf); end
    n_cmp++; if (sticky_carry !== 1'b0) begin n_err++; $display("FAIL sticky_carry_a got %b want 0", sticky_carry); end
    cycle();
    clr_sticky = 1'b0;
    n_cmp++; if (sticky_ovf !== 1'b0) begin n_err++; $display("FAIL sticky_clear got %b want 0", sticky_ovf); end
    n_cmp++; if (sticky_carry !== 1'b0) begin n_err++; $display("FAIL sticky_carry_b got %b want 0", sticky_carry); end
    in_valid = 1'b1; in_flags = 4'b1010;
    cycle();
    in_valid = 1'b0;
    n_cmp++; if ({sticky_ovf, sticky_carry} !== 2'b01) begin n_err++; $display("FAIL sticky_carry_set got %b%b want 01", sticky_ovf, sticky_carry); end
    out_ready = 1'b0;
  endtask

  task automatic test_saturation_and_reset();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_z = $urandom; in_flags = 4'($urandom_range(0, 15));
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (result_count_c4 !== 4'hF) begin n_err++; $display("FAIL sat_c4 got %h want F", result_count_c4); end
    n_cmp++; if (result_count !== 16'd17) begin n_err++; $display("FAIL sat_c16 got %0d want 17", result_count); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sat_pending got %b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_valid_c4 !== 1'b0) begin n_err++; $display("FAIL async_valid got %b/%b want 0/0", out_valid, out_valid_c4); end
    n_cmp++; if (result_count !== 16'd0 || result_count_c4 !== 4'd0) begin n_err++; $display("FAIL async_count got %0d/%0d want 0/0", result_count, result_count_c4); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL async_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [35:0] head;
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      n_cmp++; if (out_valid !== (exp_q.size() != 0)) begin n_err++; $display("FAIL rnd_valid c=%0d got %b want %b", c, out_valid, exp_q.size() != 0); end
      n_cmp++; if (in_ready !== (exp_q.size() != DEPTH)) begin n_err++; $display("FAIL rnd_in_ready c=%0d got %b want %b", c, in_ready, exp_q.size() != DEPTH); end
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        n_cmp++; if ({out_flags, out_z} !== head) begin n_err++; $display("FAIL rnd_data c=%0d got %h want %h", c, {out_flags, out_z}, head); end
      end
      n_cmp++; if ({sticky_ovf, sticky_carry} !== {m_sovf, m_scarry}) begin n_err++; $display("FAIL rnd_sticky c=%0d got %b%b want %b%b", c, sticky_ovf, sticky_carry, m_sovf, m_scarry); end
      n_cmp++; if (result_count !== 16'(m_cnt16) || result_count_c4 !== 4'(m_cnt4)) begin
        n_err++; $display("FAIL rnd_count c=%0d got %0d/%0d want %0d/%0d", c, result_count, result_count_c4, m_cnt16, m_cnt4);
      end
      in_valid   = ($urandom_range(0, 99) < 60);
      out_ready  = ($urandom_range(0, 99) < 50);
      clr_sticky = ($urandom_range(0, 99) < 8);
      in_z       = $urandom;
      in_flags   = ($urandom_range(0, 99) < 20) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 15)) & 4'b1100;
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_drain();
    test_full_push_pop();
    test_sticky();
    test_saturation_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
